sync_fifo_param: RTL

Parametrised single-clock FIFO, the successor to the fixed 8x56 key FIFO in the DES datapath. Buffers round-key or data words between producer and consumer stages. Adds over the previous generation:
- generic width and depth
- full flag with write rejection
- occupancy count and almost-full/almost-empty thresholds
- read-valid strobe
- defined behaviour for simultaneous read and write at every fill level

---
 rtl/sync_fifo_pkg.sv | 24 ++
 rtl/fifo_mem_dp.sv | 35 +++
 rtl/sync_fifo_param.sv | 102 ++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the parametrised sync FIFO.
package sync_fifo_pkg;

  localparam int DES_KEY_W = 56;

  // Elaboration-time ceil(log2(n)); clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Occupancy needs one more bit than the pointers to represent DEPTH itself.
  function automatic int count_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// WIDTH x DEPTH storage with one synchronous write port and a registered,
// read-enabled output port.
module fifo_mem_dp
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DES_KEY_W,
  parameter int DEPTH = 8,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM/LUTRAM; only the
  // output register is cleared, which is what the consumer observes.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A same-address write on this edge is not visible here: a full-FIFO
  // simultaneous read must return the old word.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, threshold flags and read strobe.
// Optional sticky overflow/underflow outputs: define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DES_KEY_W,
  parameter int DEPTH     = 8,
  parameter int AW        = clog2(DEPTH), // derived; do not override
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  typedef logic [AW-1:0]             ptr_t;
  typedef logic [count_w(DEPTH)-1:0] count_t;

  ptr_t   wr_ptr;
  ptr_t   rd_ptr;
  count_t count_q;
  logic   rd_ok;
  logic   wr_ok;

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  // NOTE: all state uses non-blocking assignment so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      rd_valid <= rd_ok;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + count_t'(1);
        2'b01:   count_q <= count_q - count_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  fifo_mem_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Flags decode only the registered count, so they never glitch mid-cycle.
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (int'(count_q) == DEPTH);
  assign almost_full  = (int'(count_q) >= AFULL_TH);
  assign almost_empty = (int'(count_q) <= AEMPTY_TH);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_ok) overflow  <= 1'b1;
      if (rd_en && !rd_ok) underflow <= 1'b1;
    end
  end
`endif

endmodule
